// File: rtl/stream_transpose_pkg.sv
// Shared types and helpers for the streaming N x N matrix transposer.
package stream_transpose_pkg;

  typedef enum logic {
    FILL,
    DRAIN
  } state_t;

  // Counter index width; a 1-bit floor keeps N=2 (and degenerate sizes) legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_transpose_if.sv
// Element-serial input and output handshake bundle of the transposer.
interface stream_transpose_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/stream_transpose_index_counter.sv
// 2-D row/column index counter: column is inner, both wrap at N-1.
module tp_index_counter #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic          clk,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [IW-1:0] o_row,
  output logic [IW-1:0] o_col,
  output logic          o_at_last
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] r_row;
  logic [IW-1:0] r_col;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (r_col == LAST) begin
        r_col <= '0;
        r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row     = r_row;
  assign o_col     = r_col;
  assign o_at_last = (r_row == LAST) && (r_col == LAST);

endmodule

// File: rtl/stream_transpose.sv
// Streaming N x N transposer: fills a register matrix row-major, drains it column-major.
module stream_transpose
  import stream_transpose_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  stream_transpose_if.slave bus
);

  localparam int unsigned IW = idx_width(N);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_active;
  logic [DATA_WIDTH-1:0] r_mem [N][N];

  logic                  w_in_ready;
  logic                  w_out_valid;
  logic                  w_out_last;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic [IW-1:0]         w_wr_i, w_wr_j, w_rd_i, w_rd_j;
  logic                  w_wr_at_last, w_rd_at_last;

  // r_active holds in_ready low through reset and releases it one cycle later.
  always_ff @(posedge clk) begin
    r_active <= !rst;
    if (rst) r_state <= FILL;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FILL:    if (w_in_fire && w_wr_at_last)  w_next_state = DRAIN;
      DRAIN:   if (w_out_fire && w_rd_at_last) w_next_state = FILL;
      default: w_next_state = FILL;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_last  = 1'b0;
    w_out_data  = '0;
    if (r_state == FILL) begin
      w_in_ready = r_active;
    end else begin
      w_out_valid = 1'b1;
      w_out_last  = w_rd_at_last;
      w_out_data  = r_mem[w_rd_j][w_rd_i];
    end
  end

  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = w_out_valid && bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_last;
  assign bus.out_data  = w_out_data;

  always_ff @(posedge clk) begin
    if (r_state == FILL && w_in_fire) r_mem[w_wr_i][w_wr_j] <= bus.in_data;
  end

  // Both counters wrap to (0,0) on their final element, so only reset clears them.
  tp_index_counter #(.N(N), .IW(IW)) u_wr_cnt (
    .clk       (clk),
    .i_clr     (rst),
    .i_en      (w_in_fire),
    .o_row     (w_wr_i),
    .o_col     (w_wr_j),
    .o_at_last (w_wr_at_last)
  );

  tp_index_counter #(.N(N), .IW(IW)) u_rd_cnt (
    .clk       (clk),
    .i_clr     (rst),
    .i_en      (w_out_fire),
    .o_row     (w_rd_i),
    .o_col     (w_rd_j),
    .o_at_last (w_rd_at_last)
  );

endmodule

// File: tb/tb_stream_transpose.sv
// Scoreboard bench for stream_transpose at N=4/8-bit and N=2/16-bit.
module tb_stream_transpose;

  logic clk = 1'b0;
  logic rst4 = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  stream_transpose_if #(.DATA_WIDTH(8))  bus4 ();
  stream_transpose_if #(.DATA_WIDTH(16)) bus2 ();

  stream_transpose #(.N(4), .DATA_WIDTH(8)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  stream_transpose #(.N(2), .DATA_WIDTH(16)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mbuf [16];
  int unsigned mcnt = 0;
  logic [15:0] exp_d [$];
  bit          exp_l [$];
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on the selected DUT; outputs checked at the negedge.
  task automatic step(input bit sel, input bit v, input logic [15:0] d, input bit r, output bit acc);
    int unsigned n;
    logic        irdy, ovld, olast;
    logic [15:0] odat, e;
    bit          el;
    bit          pending;
    n = sel ? 2 : 4;
    if (!sel) begin
      bus4.in_valid = v; bus4.in_data = d[7:0]; bus4.out_ready = r;
    end else begin
      bus2.in_valid = v; bus2.in_data = d; bus2.out_ready = r;
    end
    @(negedge clk);
    irdy  = sel ? bus2.in_ready  : bus4.in_ready;
    ovld  = sel ? bus2.out_valid : bus4.out_valid;
    olast = sel ? bus2.out_last  : bus4.out_last;
    odat  = sel ? bus2.out_data  : {8'h00, bus4.out_data};
    pending = (exp_d.size() != 0);
    chk("out_valid", ovld, pending);
    chk("in_ready", irdy, !pending);
    if (prev_stall) begin
      chk("stall_hold_data", odat, prev_data);
      chk("stall_hold_last", olast, prev_last);
    end
    if (ovld) begin
      if (r && pending) begin
        e  = exp_d.pop_front();
        el = exp_l.pop_front();
        chk("out_data", odat, e);
        chk("out_last", olast, el);
      end
    end else begin
      chk("idle_out_data", odat, 16'h0);
      chk("idle_out_last", olast, 1'b0);
    end
    prev_stall = ovld && !r;
    prev_data  = odat;
    prev_last  = olast;
    acc = v && irdy;
    if (acc) begin
      mbuf[mcnt] = d;
      mcnt++;
      if (mcnt == n * n) begin
        for (int unsigned i = 0; i < n; i++)
          for (int unsigned j = 0; j < n; j++) begin
            exp_d.push_back(mbuf[j * n + i]);
            exp_l.push_back(i == n - 1 && j == n - 1);
          end
        mcnt = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse(input bit sel, input int cycles);
    logic [15:0] odat;
    if (!sel) begin rst4 = 1'b1; bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; end
    else      begin rst2 = 1'b1; bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; end
    @(posedge clk); #1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      odat = sel ? bus2.out_data : {8'h00, bus4.out_data};
      chk("rst_in_ready", sel ? bus2.in_ready : bus4.in_ready, 1'b0);
      chk("rst_out_valid", sel ? bus2.out_valid : bus4.out_valid, 1'b0);
      chk("rst_out_data", odat, 16'h0);
      @(posedge clk); #1;
    end
    if (!sel) rst4 = 1'b0; else rst2 = 1'b0;
    mcnt = 0;
    exp_d.delete();
    exp_l.delete();
    prev_stall = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic feed(input bit sel, input logic [15:0] base, input int cnt);
    bit acc;
    int k = 0;
    for (int c = 0; c < 200 && k < cnt; c++) begin
      step(sel, 1'b1, base + 16'(k), 1'b1, acc);
      if (acc) k++;
    end
    chk("feed_complete", 16'(k), 16'(cnt));
  endtask

  task automatic drain(input bit sel, input bit toggle, input bit junk);
    bit acc;
    bit r;
    for (int c = 0; c < 200 && exp_d.size() != 0; c++) begin
      r = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      step(sel, junk, 16'hFF, r, acc);
    end
    chk("drain_complete", 16'(exp_d.size()), 16'h0);
    step(sel, 1'b0, 16'h0, 1'b1, acc);
  endtask

  initial begin
    bit acc;
    int k;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;

    rst_pulse(1'b0, 2);
    rst_pulse(1'b1, 2);

    feed(1'b0, 16'h00, 16);
    drain(1'b0, 1'b0, 1'b0);

    feed(1'b0, 16'h00, 16);
    drain(1'b0, 1'b1, 1'b0);

    feed(1'b0, 16'h50, 16);
    drain(1'b0, 1'b0, 1'b1);
    feed(1'b0, 16'h20, 16);
    drain(1'b0, 1'b0, 1'b0);

    feed(1'b0, 16'h30, 6);
    rst_pulse(1'b0, 2);
    feed(1'b0, 16'h10, 16);
    drain(1'b0, 1'b0, 1'b0);

    k = 0;
    for (int c = 0; c < 1500 && (k < 32 || exp_d.size() != 0); c++) begin
      step(1'b0, (k < 32) && ($urandom_range(0, 3) != 0), 16'h40 + 16'(k),
           1'($urandom_range(0, 1)), acc);
      if (acc) k++;
    end
    chk("random_complete", 16'((k == 32) && (exp_d.size() == 0)), 16'h1);

    step(1'b1, 1'b1, 16'hAAAA, 1'b1, acc);
    step(1'b1, 1'b1, 16'hBBBB, 1'b1, acc);
    step(1'b1, 1'b1, 16'hCCCC, 1'b1, acc);
    step(1'b1, 1'b1, 16'hDDDD, 1'b1, acc);
    drain(1'b1, 1'b0, 1'b0);
    rst_pulse(1'b1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_transpose.md
# stream_transpose

Streaming N×N matrix transposer with valid/ready handshakes. It accepts one element per cycle in row-major order, buffers the full matrix in a register array, then emits it in column-major order. The output stream is therefore the row-major stream of the transposed matrix. It sits between element-serial producers/consumers and the flat-bus matrix blocks of the approximate-arithmetic datapath, so a matrix can be transposed without an N·N·DATA_WIDTH-wide bus.

## Interface
- N, 8, matrix dimension; N ≥ 2
- DATA_WIDTH, 8, element width in bits

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data holds a valid element
- in_ready  out  1  block accepts an element this cycle
- in_data  in  DATA_WIDTH  element A[i][j], row-major (i outer, j inner)
- out_valid  out  1  out_data holds a valid element
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  DATA_WIDTH  element B[i][j] = A[j][i], row-major
- out_last  out  1  high with the final (N·N-th) output element of a matrix

## Operation
- State machine: FILL and DRAIN. Reset state is FILL.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, store in_data at mem[wr_i][wr_j], then advance (wr_i,wr_j): wr_j increments and wraps N-1→0, and wr_i increments on that wrap.
  - Accepting element (N-1,N-1) → DRAIN; write counters return to (0,0).
- DRAIN:
  - in_ready=0, out_valid=1, out_data = mem[rd_j][rd_i].
  - (rd_i,rd_j) start at (0,0) with rd_j inner.
  - out_last = (rd_i==N-1 && rd_j==N-1).
  - On out_valid&&out_ready, advance (rd_i,rd_j).
  - Accepting the last element → FILL; read counters return to (0,0).
- in_valid while in_ready=0 is ignored, with no storage and no error.
- out_data and out_last are forced to 0 whenever out_valid=0.
- Data passes unmodified; there is no arithmetic on element values.
- Reset values: in_ready=0 while rst is high, 1 on the first cycle after rst is released; out_valid=0, out_last=0, out_data=0. mem contents are not reset.
- Reset mid-operation, in either state: the partial matrix is discarded, counters go to (0,0), and the state goes to FILL. The next accepted element is A[0][0].

## Timing
- Input throughput: 1 element/cycle when in_valid is held high.
- Output throughput: 1 element/cycle when out_ready is held high.
- Latency: out_valid rises on the cycle after A[N-1][N-1] is accepted. Output element B[0][0] is therefore available one cycle after the last input handshake.
- in_ready rises on the cycle after the out_last handshake. There is no overlap of fill and drain.
- Minimum period per matrix: 2·N·N cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and the counters hold stable.
- Handshake signals have no combinational path input→output. in_ready and out_valid are decoded from the state register only.
- out_data is a mux of mem flops indexed by registered counters. There is no extra output register.

## Structure
- Package stream_transpose_pkg:
  - state enum {FILL, DRAIN}
  - index-width function clog2 of N (minimum 1)
- Sub-module tp_index_counter, instantiated twice (write and read):
  - 2-D row/column counter with enable, synchronous clear, wrap at N-1, and a combinational at_last flag.
- mem is an N×N array of DATA_WIDTH registers. The write is enabled only in FILL on a handshake.

## Test plan
- N=4, DATA_WIDTH=8, inputs 0x00..0x0F back-to-back, out_ready=1 → outputs 00,04,08,0C,01,05,09,0D,02,06,0A,0E,03,07,0B,0F. out_last only with 0F. First out_valid one cycle after input 0F is accepted.
- Same matrix with out_ready toggling 1,0,0,1,…:
  - out_data is held while stalled.
  - The sequence is identical to the previous test.
  - in_ready stays 0 until the cycle after the 0F handshake.
- in_valid=1 with junk data 0xFF throughout DRAIN → no junk accepted. The next matrix after the drain reads back correctly.
- rst pulsed after 6 elements accepted, then 16 fresh elements 0x10..0x1F → outputs 10,14,18,1C,…,1F. None of the pre-reset data appears.
- Two matrices streamed continuously, with random in_valid gaps and random out_ready → each output equals the transpose of its own input. in_valid gaps only stall acceptance and cause no data loss.
- N=2, DATA_WIDTH=16, inputs 0xAAAA,0xBBBB,0xCCCC,0xDDDD → outputs AAAA,CCCC,BBBB,DDDD, with out_last on DDDD. rst held high → in_ready=0, out_valid=0, out_data=0.
